// File: rtl/draw_arb_pkg.sv
// Shared types and defaults for the screen-drawer arbiter.
// Optional erase pass is controlled by the DRAW_ARB_ERASE_EN macro in draw_arbiter.
package draw_arb_pkg;

   localparam int CW_DEF   = 9;
   localparam int COLW_DEF = 3;
   localparam logic [COLW_DEF-1:0] BG_COLOR_DEF = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ERASE_REQ  = 3'd1,
      S_ERASE_WAIT = 3'd2,
      S_DRAW_REQ   = 3'd3,
      S_DRAW_WAIT  = 3'd4,
      S_ACK        = 3'd5
   } state_e;

   // Rectangle as handed to the fill engine; fields are CW_DEF wide.
   typedef struct packed {
      logic [CW_DEF-1:0] x;
      logic [CW_DEF-1:0] y;
      logic [CW_DEF-1:0] w;
      logic [CW_DEF-1:0] h;
   } rect_t;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Round-robin first-one search with wrap: scans ptr_i, ptr_i+1, ... mod N.
// Purely combinational so other overlay arbiters can reuse it.
module rr_picker #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // First asserted request at or after the pointer, wrapping around
   always_comb begin
      int j;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Shares one rectangle fill engine between NUM_REQ location processors.
// Each grant optionally erases the requester's previous rectangle in BG_COLOR
// (macro DRAW_ARB_ERASE_EN), then draws the new one and pulses req_ready.
module draw_arbiter
   import draw_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int CW      = CW_DEF,
   parameter int COLW    = COLW_DEF,
   parameter logic [COLW-1:0] BG_COLOR = BG_COLOR_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*CW-1:0]   req_x,
   input  logic [NUM_REQ*CW-1:0]   req_y,
   input  logic [NUM_REQ*CW-1:0]   req_w,
   input  logic [NUM_REQ*CW-1:0]   req_h,
   input  logic [NUM_REQ*COLW-1:0] req_color,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    d_valid,
   input  logic                    d_ready,
   output logic [CW-1:0]           d_x,
   output logic [CW-1:0]           d_y,
   output logic [CW-1:0]           d_w,
   output logic [CW-1:0]           d_h,
   output logic [COLW-1:0]         d_color,
   input  logic                    d_done,
   output logic                    busy,
   output logic [NUM_REQ-1:0]      grant
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d, rdy_q, rdy_d;
   logic                 dval_q, dval_d;
   rect_t                cmd_q, cmd_d, snap_q, snap_d, pick_rect;
   logic [COLW-1:0]      dcol_q, dcol_d, scol_q, scol_d, pick_col;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;
`ifdef DRAW_ARB_ERASE_EN
   rect_t                last_q [NUM_REQ];
   logic [NUM_REQ-1:0]   lv_q, lv_d;
   logic                 last_we;
`endif

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Slice the candidate requester's rectangle and colour out of the packed buses
   always_comb begin
      pick_rect.x = req_x[pick_idx*CW +: CW];
      pick_rect.y = req_y[pick_idx*CW +: CW];
      pick_rect.w = req_w[pick_idx*CW +: CW];
      pick_rect.h = req_h[pick_idx*CW +: CW];
      pick_col    = req_color[pick_idx*COLW +: COLW];
   end

   // Transaction sequencing: arbitrate, (erase), draw, acknowledge
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      rdy_d   = '0;
      dval_d  = dval_q;
      cmd_d   = cmd_q;
      dcol_d  = dcol_q;
      snap_d  = snap_q;
      scol_d  = scol_q;
`ifdef DRAW_ARB_ERASE_EN
      lv_d    = lv_q;
      last_we = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               gidx_d  = pick_idx;
               grant_d = pick_gnt;
               snap_d  = pick_rect;
               scol_d  = pick_col;
               dval_d  = 1'b1;
`ifdef DRAW_ARB_ERASE_EN
               if (lv_q[pick_idx]) begin
                  cmd_d   = last_q[pick_idx];
                  dcol_d  = BG_COLOR;
                  state_d = S_ERASE_REQ;
               end else
`endif
               begin
                  cmd_d   = pick_rect;
                  dcol_d  = pick_col;
                  state_d = S_DRAW_REQ;
               end
            end
         end
`ifdef DRAW_ARB_ERASE_EN
         S_ERASE_REQ: begin
            if (d_ready) begin
               dval_d  = 1'b0;
               state_d = S_ERASE_WAIT;
            end
         end
         S_ERASE_WAIT: begin
            if (d_done) begin
               cmd_d   = snap_q;
               dcol_d  = scol_q;
               dval_d  = 1'b1;
               state_d = S_DRAW_REQ;
            end
         end
`endif
         S_DRAW_REQ: begin
            if (d_ready) begin
               dval_d  = 1'b0;
               state_d = S_DRAW_WAIT;
            end
         end
         S_DRAW_WAIT: begin
            if (d_done) begin
               rdy_d   = grant_q;
               state_d = S_ACK;
`ifdef DRAW_ARB_ERASE_EN
               lv_d[gidx_q] = 1'b1;
               last_we      = 1'b1;
`endif
            end
         end
         S_ACK: begin
            ptr_d   = (gidx_q == IW'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and command registers; reset abandons any in-flight fill
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         rdy_q   <= '0;
         dval_q  <= 1'b0;
         cmd_q   <= '0;
         dcol_q  <= '0;
`ifdef DRAW_ARB_ERASE_EN
         lv_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         rdy_q   <= rdy_d;
         dval_q  <= dval_d;
         cmd_q   <= cmd_d;
         dcol_q  <= dcol_d;
`ifdef DRAW_ARB_ERASE_EN
         lv_q    <= lv_d;
`endif
      end
   end

   // Snapshot of the granted request, held for the whole transaction
   always_ff @(posedge clock) begin
      snap_q <= snap_d;
      scol_q <= scol_d;
   end

`ifdef DRAW_ARB_ERASE_EN
   // Remember each requester's last drawn rectangle for the next erase
   always_ff @(posedge clock) begin
      if (last_we) last_q[gidx_q] <= snap_q;
   end
`endif

   assign req_ready = rdy_q;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);
   assign d_valid   = dval_q;
   assign d_x       = cmd_q.x;
   assign d_y       = cmd_q.y;
   assign d_w       = cmd_q.w;
   assign d_h       = cmd_q.h;
   assign d_color   = dcol_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus randomized
// transactions against a per-requester reference model.
module tb_draw_arbiter;
   import draw_arb_pkg::*;

   localparam int N = 3, CW = 9, COLW = 3;
`ifdef DRAW_ARB_ERASE_EN
   localparam bit ERASE = 1'b1;
`else
   localparam bit ERASE = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N*CW-1:0]   req_x = '0, req_y = '0, req_w = '0, req_h = '0;
   logic [N*COLW-1:0] req_color = '0;
   logic [N-1:0]      req_ready;
   logic              d_valid;
   logic              d_ready = 1'b0;
   logic [CW-1:0]     d_x, d_y, d_w, d_h;
   logic [COLW-1:0]   d_color;
   logic              d_done = 1'b0;
   logic              busy;
   logic [N-1:0]      grant;

   always #5 clock = ~clock;

   draw_arbiter dut (
      .clock(clock), .reset(reset), .req_valid(req_valid),
      .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
      .req_color(req_color), .req_ready(req_ready), .d_valid(d_valid),
      .d_ready(d_ready), .d_x(d_x), .d_y(d_y), .d_w(d_w), .d_h(d_h),
      .d_color(d_color), .d_done(d_done), .busy(busy), .grant(grant)
   );

   int n_assert = 0, n_fail = 0, lat = 0;

   // Reference model: next-search start, and last drawn rectangle per requester
   int            ptr_m;
   bit            lv_m [N];
   logic [CW-1:0] lx_m [N], ly_m [N], lw_m [N], lh_m [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      lat++;
   endtask

   task automatic model_reset();
      ptr_m = 0;
      for (int i = 0; i < N; i++) lv_m[i] = 1'b0;
   endtask

   task automatic set_req(input int i, input int x, input int y, input int w, input int h, input int c);
      req_x[i*CW +: CW]       = CW'(x);
      req_y[i*CW +: CW]       = CW'(y);
      req_w[i*CW +: CW]       = CW'(w);
      req_h[i*CW +: CW]       = CW'(h);
      req_color[i*COLW +: COLW] = COLW'(c);
   endtask

   task automatic rand_inputs();
      req_valid = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
         set_req(i, $urandom, $urandom, $urandom, $urandom, $urandom);
   endtask

   // Entered at a negedge; reset is held across one rising edge
   task automatic do_reset();
      reset = 1'b1; req_valid = '0; d_ready = 1'b0; d_done = 1'b0;
      @(negedge clock);
      chk("rst.req_ready", req_ready, 0);
      chk("rst.d_valid", d_valid, 0);
      chk("rst.cmd", {d_x, d_y, d_w, d_h, d_color}, 0);
      chk("rst.grant", grant, 0);
      chk("rst.busy", busy, 0);
      reset = 1'b0;
      model_reset();
   endtask

   // Act as the fill engine for one command: check it, hold off, accept, finish
   task automatic serve(input string tag, input logic [CW-1:0] ex, input logic [CW-1:0] ey,
                        input logic [CW-1:0] ew, input logic [CW-1:0] eh, input logic [COLW-1:0] ec,
                        input int hold, input int dd, input bit noise);
      logic [63:0] exp_cmd;
      exp_cmd = {1'b1, ex, ey, ew, eh, ec};
      d_ready = 1'b0;
      chk({tag, ".cmd"}, {d_valid, d_x, d_y, d_w, d_h, d_color}, exp_cmd);
      for (int k = 0; k < hold; k++) begin
         if (noise) begin
            rand_inputs();
            d_done = 1'($urandom_range(0, 1));
         end
         tick();
         chk({tag, ".hold"}, {d_valid, d_x, d_y, d_w, d_h, d_color}, exp_cmd);
      end
      d_done = 1'b0; d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      chk({tag, ".accepted"}, d_valid, 0);
      for (int k = 0; k < dd; k++) begin
         if (noise) d_ready = 1'($urandom_range(0, 1));
         tick();
         chk({tag, ".wait"}, {d_valid, busy}, 2'b01);
      end
      d_ready = 1'b0; d_done = 1'b1;
      tick();
      d_done = 1'b0;
   endtask

   // One full transaction, entered at a negedge with the DUT idle and inputs set
   task automatic txn(input int hold, input int dd, input bit noise, output int g);
      logic [CW-1:0] sx, sy, sw, sh;
      logic [COLW-1:0] sc;
      bit er;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      if (g < 0) g = 0;
      sx = req_x[g*CW +: CW]; sy = req_y[g*CW +: CW];
      sw = req_w[g*CW +: CW]; sh = req_h[g*CW +: CW];
      sc = req_color[g*COLW +: COLW];
      er = ERASE && lv_m[g];
      lat = 0;
      tick();
      chk("txn.grant", grant, 64'd1 << g);
      chk("txn.busy", busy, 1);
      if (er) serve("erase", lx_m[g], ly_m[g], lw_m[g], lh_m[g], BG_COLOR_DEF, 0, 0, noise);
      serve("draw", sx, sy, sw, sh, sc, hold, dd, noise);
      chk("txn.ack", req_ready, 64'd1 << g);
      chk("txn.ack_grant", grant, 64'd1 << g);
      chk("txn.latency", lat, (er ? 5 : 3) + hold + dd);
      lx_m[g] = sx; ly_m[g] = sy; lw_m[g] = sw; lh_m[g] = sh;
      lv_m[g] = 1'b1;
      ptr_m = (g + 1) % N;
      tick();
      chk("txn.post_ready", req_ready, 0);
      chk("txn.post_idle", {busy, grant}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      do_reset();

      // First draw for requester 0: no erase pass
      set_req(0, 5, 0, 10, 48, 7);
      req_valid = 3'b001;
      txn(0, 0, 0, g);

      // Same requester moves: erase old rectangle (when enabled), then draw
      set_req(0, 5, 4, 10, 48, 7);
      txn(0, 0, 0, g);

      // All requesters held: round-robin from a fresh pointer
      do_reset();
      set_req(0, 1, 2, 3, 4, 1);
      set_req(1, 100, 200, 8, 40, 2);
      set_req(2, 320, 240, 4, 4, 5);
      req_valid = 3'b111;
      for (int i = 0; i < 4; i++) begin
         txn(0, 0, 0, g);
         chk("rr.order", g, i % 3);
      end

      // Drawer stalls 20 cycles in DRAW_REQ while the inputs churn
      set_req(0, 17, 33, 9, 12, 3);
      req_valid = 3'b001;
      txn(20, 2, 1, g);

      // Reset while waiting for a fill, then a stray d_done
      do_reset();
      set_req(1, 50, 60, 7, 8, 6);
      req_valid = 3'b010;
      txn(0, 0, 0, g);
      set_req(1, 51, 61, 7, 8, 6);
      lat = 0;
      tick();
      chk("abort.grant", grant, 3'b010);
      if (ERASE) serve("abort.erase", 50, 60, 7, 8, BG_COLOR_DEF, 0, 0, 0);
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      chk("abort.in_wait", {busy, d_valid}, 2'b10);
      reset = 1'b1; req_valid = '0;
      tick();
      reset = 1'b0;
      model_reset();
      chk("abort.idle", {busy, grant, d_valid, req_ready}, 0);
      d_done = 1'b1;
      tick();
      d_done = 1'b0;
      chk("abort.stray_done", {busy, req_ready, d_valid}, 0);
      tick();
      chk("abort.still_idle", {busy, req_ready}, 0);
      req_valid = 3'b010;
      txn(0, 0, 0, g);

      // Randomized traffic with stalls, slow fills and input churn
      for (int t = 0; t < 40; t++) begin
         rand_inputs();
         req_valid = N'($urandom_range(1, 7));
         txn($urandom_range(0, 3), $urandom_range(0, 2), 1'b1, g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
